ucnt_ctrl: RTL and testbench
============================

UCNT_CTRL -- requirements
Module: ucnt_ctrl

Interface
REQ-001 Parameter DIV, default 8: prescaler period in clocks between count ticks (legal 2..65535).
REQ-002 Parameter DEB, default 4: clocks a synchronized button level must remain stable before acceptance (legal 1..255).
REQ-003 ucnt_ctrl_clk  in  1  single clock; all logic rising-edge.
REQ-004 ucnt_ctrl_rst  in  1  reset, asynchronous, active-high.
REQ-005 ucnt_ctrl_btn_run  in  1  raw async start/stop button.
REQ-006 ucnt_ctrl_btn_mode  in  1  raw async mode button; selects binary vs alternate counter.
REQ-007 ucnt_ctrl_cnt_q  in  4  selected counter output, fed back from the counter/mux datapath.
REQ-008 ucnt_ctrl_sel  out  1  counter select; 1 = binary counter, 0 = alternate counter; drives the datapath sel/enable.
REQ-009 ucnt_ctrl_tick  out  1  one-clock count-enable pulse to the datapath clock input.
REQ-010 ucnt_ctrl_cnt_rst  out  1  one-clock synchronous-style reset pulse to the counters.
REQ-011 ucnt_ctrl_running  out  1  high while in RUN.

Function
REQ-012 Each button SHALL pass a 2-flop synchronizer, then a debouncer: accepted level updates only after DEB consecutive equal synchronized samples.
REQ-013 A rising edge of an accepted level SHALL produce a one-clock internal press pulse; falling edges and bounces shorter than DEB produce nothing.
REQ-014 FSM states: IDLE, RUN, SWITCH.
REQ-015 IDLE: run press -> RUN; mode press -> SWITCH; else hold.
REQ-016 RUN: run press -> IDLE; mode press -> SWITCH; run and mode press same cycle -> SWITCH (mode wins, run press discarded).
REQ-017 SWITCH: lasts exactly one clock; sel toggles on entry; cnt_rst high during SWITCH; exits to the state held before SWITCH.
REQ-018 Prescaler SHALL clear to 0 on every entry to RUN and count 0..DIV-1 only in RUN; tick asserted during the clock the prescaler equals DIV-1, then wraps to 0.
REQ-019 First tick after entering RUN SHALL occur exactly DIV clocks after the RUN entry edge; thereafter every DIV clocks.
REQ-020 tick SHALL never be high in IDLE or SWITCH, nor in the same cycle as cnt_rst.
REQ-021 Presses arriving while in SWITCH SHALL be ignored (not queued).
REQ-022 running = (state == RUN), registered output.
REQ-023 All outputs SHALL be registered; no combinational path from any input to any output.

Reset
REQ-024 Asserting ucnt_ctrl_rst SHALL immediately force: state IDLE, sel=1, tick=0, cnt_rst=0, running=0, prescaler=0, synchronizers/debouncers=0, accepted levels=0.
REQ-025 Reset asserted mid-RUN or mid-SWITCH SHALL abort without a trailing tick or cnt_rst pulse.
REQ-026 A button held high through reset release SHALL register as a press once DEB stable samples are accepted after release (accepted level starts at 0).

Configuration
REQ-027 Macro UCNT_CTRL_AUTOSTOP_EN defined: in RUN, when tick is issued while cnt_q == 4'hF, the FSM SHALL move to IDLE on the next clock (counter wraps to 0 on that tick, then stops); running drops the same edge.
REQ-028 Macro UCNT_CTRL_AUTOSTOP_EN undefined: cnt_q SHALL be ignored; RUN continues indefinitely with wrap-around handled solely by the counter.

Verification
REQ-029 Reset, DIV=8, DEB=4: sel=1, running=0, tick=0; clean run press -> running=1, ticks every 8 clocks, first tick 8 clocks after RUN entry.
REQ-030 Bouncy run press (3-clock high glitches, DEB=4) -> no state change; steady press -> exactly one RUN entry.
REQ-031 In RUN, mode press -> one-clock SWITCH with cnt_rst=1, sel 1->0, tick=0, then RUN resumes with prescaler cleared.
REQ-032 Simultaneous run and mode press in RUN -> SWITCH then RUN; running never drops except during SWITCH.
REQ-033 UCNT_CTRL_AUTOSTOP_EN defined, cnt_q=4'hF at a tick -> IDLE next clock, no further ticks; undefined -> ticks continue.
REQ-034 Reset asserted 3 clocks into RUN -> all outputs at reset values asynchronously, no tick within the following DIV clocks.

Source files
------------

// File: rtl/ucnt_ctrl.sv
// Start/stop and mode controller for a 4-bit counter datapath: debounced buttons,
// IDLE/RUN/SWITCH FSM and a DIV-clock tick prescaler. Optional UCNT_CTRL_AUTOSTOP_EN stops RUN on counter wrap.

module ucnt_ctrl_btn #(
    parameter int DEB = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic press
);

    localparam logic [7:0] DEB_LAST = 8'(DEB - 1);

    logic       sync1_r;
    logic       sync2_r;
    logic       level_r;
    logic [7:0] deb_cnt_r;
    logic       press_r;

    // Synchronizer, stability counter, accepted level and rising-edge press pulse.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_r   <= 1'b0;
            sync2_r   <= 1'b0;
            level_r   <= 1'b0;
            deb_cnt_r <= 8'd0;
            press_r   <= 1'b0;
        end else begin
            sync1_r <= btn;
            sync2_r <= sync1_r;
            if (sync2_r != level_r) begin
                // A differing sample is the DEB-th in a row once the counter reaches DEB-1.
                if (deb_cnt_r == DEB_LAST) begin
                    level_r   <= sync2_r;
                    deb_cnt_r <= 8'd0;
                    press_r   <= sync2_r;
                end else begin
                    deb_cnt_r <= deb_cnt_r + 8'd1;
                    press_r   <= 1'b0;
                end
            end else begin
                deb_cnt_r <= 8'd0;
                press_r   <= 1'b0;
            end
        end
    end

    assign press = press_r;

endmodule

module ucnt_ctrl #(
    parameter int DIV = 8,
    parameter int DEB = 4
) (
    input  logic       ucnt_ctrl_clk,
    input  logic       ucnt_ctrl_rst,
    input  logic       ucnt_ctrl_btn_run,
    input  logic       ucnt_ctrl_btn_mode,
    input  logic [3:0] ucnt_ctrl_cnt_q,
    output logic       ucnt_ctrl_sel,
    output logic       ucnt_ctrl_tick,
    output logic       ucnt_ctrl_cnt_rst,
    output logic       ucnt_ctrl_running
);

    localparam logic [15:0] DIV_LAST = 16'(DIV - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'b00,
        ST_RUN    = 2'b01,
        ST_SWITCH = 2'b10
    } state_t;

    state_t      state_r;
    state_t      state_nxt_s;
    state_t      ret_r;
    state_t      ret_nxt_s;
    logic [15:0] presc_r;
    logic [15:0] presc_nxt_s;
    logic        tick_r;
    logic        tick_nxt_s;
    logic        sel_r;
    logic        sel_nxt_s;
    logic        cnt_rst_r;
    logic        running_r;
    logic        press_run_s;
    logic        press_mode_s;
    logic        autostop_s;

    ucnt_ctrl_btn #(.DEB(DEB)) u_btn_run (
        .clk   (ucnt_ctrl_clk),
        .rst   (ucnt_ctrl_rst),
        .btn   (ucnt_ctrl_btn_run),
        .press (press_run_s)
    );

    ucnt_ctrl_btn #(.DEB(DEB)) u_btn_mode (
        .clk   (ucnt_ctrl_clk),
        .rst   (ucnt_ctrl_rst),
        .btn   (ucnt_ctrl_btn_mode),
        .press (press_mode_s)
    );

`ifdef UCNT_CTRL_AUTOSTOP_EN
    // The counter wraps on this tick, so RUN ends on the following edge.
    assign autostop_s = tick_r && (ucnt_ctrl_cnt_q == 4'hF);
`else
    logic cnt_q_unused_s;
    assign cnt_q_unused_s = ^ucnt_ctrl_cnt_q;
    assign autostop_s     = 1'b0;
`endif

    // Next-state logic; mode press has priority so a simultaneous run press is discarded.
    always_comb begin
        state_nxt_s = state_r;
        ret_nxt_s   = ret_r;
        case (state_r)
            ST_IDLE: begin
                if (press_mode_s) begin
                    state_nxt_s = ST_SWITCH;
                    ret_nxt_s   = ST_IDLE;
                end else if (press_run_s) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (press_mode_s) begin
                    state_nxt_s = ST_SWITCH;
                    ret_nxt_s   = ST_RUN;
                end else if (press_run_s || autostop_s) begin
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_RUN;
                end
            end
            ST_SWITCH: begin
                if (ret_r == ST_RUN) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
                ret_nxt_s   = ST_IDLE;
            end
        endcase
    end

    // Prescaler only advances while staying in RUN, so every RUN entry restarts it at zero.
    always_comb begin
        presc_nxt_s = 16'd0;
        tick_nxt_s  = 1'b0;
        if ((state_r == ST_RUN) && (state_nxt_s == ST_RUN)) begin
            if (presc_r == DIV_LAST) begin
                presc_nxt_s = 16'd0;
                tick_nxt_s  = 1'b1;
            end else begin
                presc_nxt_s = presc_r + 16'd1;
                tick_nxt_s  = 1'b0;
            end
        end else begin
            presc_nxt_s = 16'd0;
            tick_nxt_s  = 1'b0;
        end
    end

    // Counter select flips on the edge that enters SWITCH.
    always_comb begin
        sel_nxt_s = sel_r;
        if ((state_nxt_s == ST_SWITCH) && (state_r != ST_SWITCH)) begin
            sel_nxt_s = ~sel_r;
        end else begin
            sel_nxt_s = sel_r;
        end
    end

    // State, prescaler and registered outputs.
    always_ff @(posedge ucnt_ctrl_clk or posedge ucnt_ctrl_rst) begin
        if (ucnt_ctrl_rst) begin
            state_r   <= ST_IDLE;
            ret_r     <= ST_IDLE;
            presc_r   <= 16'd0;
            tick_r    <= 1'b0;
            sel_r     <= 1'b1;
            cnt_rst_r <= 1'b0;
            running_r <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            ret_r     <= ret_nxt_s;
            presc_r   <= presc_nxt_s;
            tick_r    <= tick_nxt_s;
            sel_r     <= sel_nxt_s;
            cnt_rst_r <= (state_nxt_s == ST_SWITCH);
            running_r <= (state_nxt_s == ST_RUN);
        end
    end

    assign ucnt_ctrl_sel     = sel_r;
    assign ucnt_ctrl_tick    = tick_r;
    assign ucnt_ctrl_cnt_rst = cnt_rst_r;
    assign ucnt_ctrl_running = running_r;

endmodule

// File: tb/tb_ucnt_ctrl.sv
// Directed bench for ucnt_ctrl (DIV=8, DEB=4); expectations follow UCNT_CTRL_AUTOSTOP_EN when defined.

module tb_ucnt_ctrl;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       btn_run = 1'b0;
    logic       btn_mode = 1'b0;
    logic [3:0] cnt_q = 4'h0;
    logic       sel;
    logic       tick;
    logic       cnt_rst;
    logic       running;

    int checks_cnt = 0;
    int errors_cnt = 0;

    ucnt_ctrl #(.DIV(8), .DEB(4)) dut (
        .ucnt_ctrl_clk     (clk),
        .ucnt_ctrl_rst     (rst),
        .ucnt_ctrl_btn_run (btn_run),
        .ucnt_ctrl_btn_mode(btn_mode),
        .ucnt_ctrl_cnt_q   (cnt_q),
        .ucnt_ctrl_sel     (sel),
        .ucnt_ctrl_tick    (tick),
        .ucnt_ctrl_cnt_rst (cnt_rst),
        .ucnt_ctrl_running (running)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks_cnt++;
        if (got !== exp) begin
            errors_cnt++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Holds the buttons long enough for one accepted press; returns on the edge the FSM reacts.
    task automatic press_btn(input logic r, input logic m);
        btn_run  = r;
        btn_mode = m;
        step(7);
        btn_run  = 1'b0;
        btn_mode = 1'b0;
    endtask

    initial begin
        step(2);
        check("rst_sel", 32'(sel), 32'd1);
        check("rst_running", 32'(running), 32'd0);
        check("rst_tick", 32'(tick), 32'd0);
        check("rst_cnt_rst", 32'(cnt_rst), 32'd0);
        rst = 1'b0;
        step(2);

        // Three-clock glitches must never be accepted.
        for (int g = 0; g < 3; g++) begin
            btn_run = 1'b1;
            step(3);
            btn_run = 1'b0;
            step(3);
            check("bounce_running", 32'(running), 32'd0);
        end
        step(8);
        check("bounce_idle", 32'(running), 32'd0);

        // Clean press: RUN entered on the 7th edge after the input goes high.
        btn_run = 1'b1;
        for (int i = 1; i <= 7; i++) begin
            step(1);
            if (i == 6) check("run_not_yet", 32'(running), 32'd0);
            if (i == 7) check("run_entry", 32'(running), 32'd1);
        end
        btn_run = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            step(1);
            check($sformatf("run_tick_%0d", j), 32'(tick), 32'((j % 8) == 0));
        end
        check("run_sel", 32'(sel), 32'd1);

        // Mode press in RUN: one SWITCH clock, then RUN with a fresh prescaler.
        press_btn(1'b0, 1'b1);
        check("sw_cnt_rst", 32'(cnt_rst), 32'd1);
        check("sw_sel", 32'(sel), 32'd0);
        check("sw_tick", 32'(tick), 32'd0);
        check("sw_running", 32'(running), 32'd0);
        step(1);
        check("sw_back_running", 32'(running), 32'd1);
        check("sw_back_cnt_rst", 32'(cnt_rst), 32'd0);
        for (int k = 1; k <= 8; k++) begin
            step(1);
            check($sformatf("sw_tick_%0d", k), 32'(tick), 32'(k == 8));
        end

        // Simultaneous run+mode: mode wins, RUN resumes.
        btn_run  = 1'b1;
        btn_mode = 1'b1;
        step(6);
        check("both_pre_running", 32'(running), 32'd1);
        step(1);
        btn_run  = 1'b0;
        btn_mode = 1'b0;
        check("both_cnt_rst", 32'(cnt_rst), 32'd1);
        check("both_sel", 32'(sel), 32'd1);
        check("both_sw_running", 32'(running), 32'd0);
        step(1);
        check("both_back_running", 32'(running), 32'd1);
        step(10);
        check("both_still_running", 32'(running), 32'd1);

        // Run press in RUN stops; no ticks in IDLE.
        press_btn(1'b1, 1'b0);
        check("stop_running", 32'(running), 32'd0);
        check("stop_cnt_rst", 32'(cnt_rst), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            step(1);
            check("idle_tick", 32'(tick), 32'd0);
        end

        // Mode press in IDLE: SWITCH then back to IDLE.
        press_btn(1'b0, 1'b1);
        check("isw_cnt_rst", 32'(cnt_rst), 32'd1);
        check("isw_sel", 32'(sel), 32'd0);
        check("isw_running", 32'(running), 32'd0);
        step(1);
        check("isw_back_running", 32'(running), 32'd0);
        check("isw_back_cnt_rst", 32'(cnt_rst), 32'd0);
        step(8);

        // Asynchronous reset three clocks into RUN.
        press_btn(1'b1, 1'b0);
        check("rr_entry", 32'(running), 32'd1);
        step(3);
        #2 rst = 1'b1;
        #1;
        check("rr_running", 32'(running), 32'd0);
        check("rr_sel", 32'(sel), 32'd1);
        check("rr_tick", 32'(tick), 32'd0);
        check("rr_cnt_rst", 32'(cnt_rst), 32'd0);
        step(1);
        rst = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            check("rr_no_tick", 32'(tick), 32'd0);
            check("rr_idle", 32'(running), 32'd0);
        end

        // Counter at 4'hF when a tick is issued.
        press_btn(1'b1, 1'b0);
        cnt_q = 4'hF;
        for (int j = 1; j <= 8; j++) begin
            step(1);
            check($sformatf("as_tick_%0d", j), 32'(tick), 32'(j == 8));
        end
        step(1);
`ifdef UCNT_CTRL_AUTOSTOP_EN
        check("as_running", 32'(running), 32'd0);
        for (int k = 1; k <= 16; k++) begin
            step(1);
            check("as_no_tick", 32'(tick), 32'd0);
        end
`else
        check("as_running", 32'(running), 32'd1);
        step(7);
        check("as_next_tick", 32'(tick), 32'd1);
`endif

        $display("CHECKS %0d ERRORS %0d", checks_cnt, errors_cnt);
        $finish;
    end

endmodule
